// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory address generator.
package dmem_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_LEN_W  = 3;

    // Channel index width; a single channel still needs a 1-bit select port.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_W = ch_width(DEF_NUM_CH);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/dmem_base_regfile.sv
// Per-channel base address registers: synchronous write, combinational read.
module dmem_base_regfile
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_CH = DEF_NUM_CH,
    localparam int CH_W  = ch_width(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [CH_W-1:0]   wr_idx_i,
    input  logic [ADDR_W-1:0] wr_data_i,
    input  logic [CH_W-1:0]   rd_idx_i,
    output logic [ADDR_W-1:0] rd_data_o
);

    logic [ADDR_W-1:0] base_q [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_base
        // One base register per channel, cleared on reset, written on a matching strobe.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                base_q[i] <= '0;
            end else if (we_i && (wr_idx_i == CH_W'(i))) begin
                base_q[i] <= wr_data_i;
            end
        end
    end

    // Read port sees the pre-write value, so a same-cycle write affects only later reads.
    always_comb begin
        rd_data_o = base_q[rd_idx_i];
    end

endmodule

// File: rtl/dmem_addr_gen.sv
// M-stage data-memory address generator: source select, per-channel base
// offset, and a registered burst address stream under ready/valid.
module dmem_addr_gen
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int LEN_W  = DEF_LEN_W,
    localparam int CH_W  = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] ALU_result_M,
    input  logic [REG_W-1:0]  rt_M,
    input  logic              SW_M,
    input  logic [CH_W-1:0]   ch_M,
    input  logic [LEN_W-1:0]  len_M,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ADDR_W-1:0] cfg_base,
    output logic [ADDR_W-1:0] D_addr,
    output logic              D_valid,
    output logic              D_last,
    input  logic              D_ready,
    output logic              addr_err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] base_rd;
    logic [ADDR_W-1:0] rt_ext;
    logic [ADDR_W-1:0] alu_lo;
    logic              alu_hi;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] first_addr;
    logic              accept;
    logic              beat_done;

    dmem_base_regfile #(
        .ADDR_W (ADDR_W),
        .NUM_CH (NUM_CH)
    ) u_base (
        .clk_i     (clk),
        .rst_i     (reset),
        .we_i      (cfg_we),
        .wr_idx_i  (cfg_ch),
        .wr_data_i (cfg_base),
        .rd_idx_i  (ch_M),
        .rd_data_o (base_rd)
    );

    // Register index is zero-extended (or truncated) to the address width.
    if (REG_W >= ADDR_W) begin : g_rt_trunc
        assign rt_ext = rt_M[ADDR_W-1:0];
    end else begin : g_rt_zext
        assign rt_ext = {{(ADDR_W-REG_W){1'b0}}, rt_M};
    end

    // Any set bit above the address width flags an out-of-range ALU address.
    if (DATA_W > ADDR_W) begin : g_alu_wide
        assign alu_lo = ALU_result_M[ADDR_W-1:0];
        assign alu_hi = |ALU_result_M[DATA_W-1:ADDR_W];
    end else begin : g_alu_narrow
        assign alu_lo = ADDR_W'(ALU_result_M);
        assign alu_hi = 1'b0;
    end

    // First address of a request; carry out of the add is dropped.
    always_comb begin
        src        = SW_M ? rt_ext : alu_lo;
        first_addr = base_rd + src;
    end

    // Handshake: a new request may land on the completing last beat, no bubble.
    always_comb begin
        beat_done = (state_q == BURST) && D_ready;
        req_ready = (state_q == IDLE) || (beat_done && last_q);
        accept    = req_valid && req_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave BURST only when the last beat completes without a follow-on request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BURST;
            BURST:   if (beat_done && last_q && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: load on acceptance, advance on a completed non-last beat.
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        err_d  = err_q;
        if (accept) begin
            addr_d = first_addr;
            cnt_d  = len_M;
            last_d = (len_M == '0);
            err_d  = !SW_M && alu_hi;
        end else if (beat_done) begin
            if (last_q) begin
                last_d = 1'b0;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
                cnt_d  = cnt_q - LEN_W'(1);
                last_d = (cnt_q == LEN_W'(1));
            end
        end
    end

    // Datapath registers; D_addr keeps its final value after a burst ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
            err_q  <= err_d;
        end
    end

    // Outputs are straight from registers, so they hold stable while stalled.
    always_comb begin
        D_valid  = (state_q == BURST);
        D_addr   = addr_q;
        D_last   = last_q;
        addr_err = err_q;
    end

endmodule

// File: doc/dmem_addr_gen.md
Name: dmem_addr_gen

Overview:
- Parametrised, pipelined successor to the M-stage data-memory address select.
- Picks the source address per request: ALU_result_M low bits for loads, or rt_M for the SW_M-style register-indexed store.
- Adds a per-channel (per-thread) base offset and emits a registered address stream, optionally as a multi-beat burst, under a ready/valid handshake toward data memory.
- Sits between the EX/MEM pipeline register and the data memory port.

Parameters:
- ADDR_W, 8, data-memory address width.
- DATA_W, 64, ALU result width.
- REG_W, 5, register index width (rt_M).
- NUM_CH, 4, number of channels/threads, each with its own base register.
- LEN_W, 3, burst-length field width; a request carries len+1 beats, max 2^LEN_W.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  M-stage request present.
- req_ready  out  1  request accepted this cycle when req_valid is also 1.
- ALU_result_M  in  DATA_W  computed effective address.
- rt_M  in  REG_W  register index used as address when SW_M=1.
- SW_M  in  1  source select: 0 = ALU_result_M, 1 = rt_M.
- ch_M  in  clog2(NUM_CH)  requesting channel.
- len_M  in  LEN_W  beats minus one.
- cfg_we  in  1  base-register write strobe.
- cfg_ch  in  clog2(NUM_CH)  base register index.
- cfg_base  in  ADDR_W  base value.
- D_addr  out  ADDR_W  registered memory address.
- D_valid  out  1  D_addr is valid.
- D_last  out  1  final beat of the current request.
- D_ready  in  1  memory accepts the current beat.
- addr_err  out  1  current request's ALU address exceeded ADDR_W.

Behaviour:
- Reset (synchronous): state=IDLE; D_addr=0, D_valid=0, D_last=0, addr_err=0; all base registers=0. A reset mid-burst aborts the burst; no further beats are issued.
- Source select:
  - src = SW_M ? zero-extend(rt_M) : ALU_result_M[ADDR_W-1:0].
  - first address = (base[ch_M] + src) mod 2^ADDR_W; the carry is dropped.
- addr_err:
  - Set to 1 when SW_M=0 and ALU_result_M[DATA_W-1:ADDR_W] != 0; always 0 when SW_M=1.
  - Sampled at acceptance and held constant for every beat of the request.
- States:
  - IDLE: D_valid=0.
  - BURST: D_valid=1. A beat completes on D_valid && D_ready.
- Handshake:
  - req_ready = (state==IDLE) || (D_valid && D_last && D_ready). This is combinational, allowing back-to-back requests with no bubble.
  - D_addr, D_valid and D_last must hold stable while D_valid && !D_ready.
- Acceptance (req_valid && req_ready):
  - Next cycle: D_valid=1, D_addr=first address, D_last=(len_M==0).
  - Beat counter loads len_M.
  - Latency from acceptance to first beat on D_addr is 1 cycle.
- Beat completes but is not last: D_addr increments mod 2^ADDR_W (0xFF wraps to 0x00 at ADDR_W=8), counter decrements, and D_last=1 when the counter reaches 0.
- Last beat completes with no new request: go to IDLE and set D_valid=0, D_last=0. D_addr keeps its last value.
- cfg_we:
  - Writes base[cfg_ch] at the clock edge.
  - Base is sampled only at acceptance, so a write during a burst affects only later requests.
  - If cfg_we and acceptance hit the same channel in the same cycle, acceptance uses the old base.
- Fields ch_M, len_M, SW_M, rt_M and ALU_result_M are ignored while req_valid=0.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum {IDLE, BURST};
  - default widths ADDR_W/LEN_W;
  - clog2-based CH_W.
- One sub-module, dmem_base_regfile: NUM_CH x ADDR_W base registers with a synchronous write port and a combinational read port. The top level holds the FSM, the counter and the output registers.

Test Plan:
- Reset, then request SW_M=0, ALU_result_M=1, ch=0, len=0, D_ready=1 -> 1 cycle later D_addr=0x01, D_valid=1, D_last=1, addr_err=0; next cycle D_valid=0.
- cfg base[2]=0x10; request SW_M=1, rt_M=4, ch=2, len=3 -> D_addr 0x14, 0x15, 0x16, 0x17 on consecutive cycles, D_last only on 0x17.
- base[1]=0xFE; request ALU_result_M=0, ch=1, len=2 -> addresses 0xFE, 0xFF, 0x00 (wrap).
- ALU_result_M=64'h103, SW_M=0, len=1 -> D_addr 0x03 then 0x04, addr_err=1 on both beats. Repeat with SW_M=1, rt_M=3 -> addr_err=0.
- Burst len=2 with D_ready held low for 3 cycles on the second beat -> D_addr held stable, no beat skipped. A second request waiting during the last beat is accepted on that beat's handshake, with no idle cycle between the bursts.
- Assert reset during the second beat of a len=3 burst -> next cycle D_valid=0, D_addr=0, all bases 0. A following request at base 0 issues its first address correctly.
